// File: rtl/mod241_pkg.sv
// Shared constants, FSM state type and mod-241 reduction helpers for the
// digit-serial mod-241 multiplier.
package mod241_pkg;

  localparam int unsigned MOD = 241;
  localparam int unsigned W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [7:0] reduce8(input logic [7:0] x);
    return (x >= 8'd241) ? (x - 8'd241) : x;
  endfunction

  // 256 == 15 (mod 241): two folds bring any 13-bit value to <= 300,
  // so a single conditional subtract finishes the job.
  function automatic logic [7:0] reduce13(input logic [12:0] x);
    logic [9:0] f1;
    logic [8:0] f2;
    f1 = (10'(x[12:8]) * 10'd15) + 10'(x[7:0]);
    f2 = (9'(f1[9:8]) * 9'd15) + 9'(f1[7:0]);
    return (f2 >= 9'd241) ? 8'(f2 - 9'd241) : f2[7:0];
  endfunction

endpackage

// File: rtl/mod241_digit_serial_mul_if.sv
// Operand/result valid-ready bundle for the mod-241 digit-serial multiplier.
interface mod241_digit_serial_mul_if;
  import mod241_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_err
  );

endinterface

// File: rtl/mod241_digit_step.sv
// Combinational digit step: nxt = (2^DIGIT_W * acc + a * d) mod 241.
module mod241_digit_step
  import mod241_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [7:0]         acc,
  input  logic [7:0]         a,
  input  logic [DIGIT_W-1:0] d,
  output logic [7:0]         nxt
);

  logic [12:0] sum;

  always_comb begin
    sum = (13'(acc) << DIGIT_W) + (13'(a) * 13'(d));
    nxt = reduce13(sum);
  end

endmodule

// File: rtl/mod241_digit_serial_mul.sv
// Digit-serial p = (a*b) mod 241, MSB digit of b first, valid/ready on both sides.
// Optional operand range flag on out_err when MOD241_RANGE_CHECK_EN is defined.
module mod241_digit_serial_mul
  import mod241_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MOD     = 241
) (
  input logic                       clk,
  input logic                       rst_n,
  mod241_digit_serial_mul_if.slave  bus
);

  localparam int unsigned NDIG = 8 / DIGIT_W;

  if (MOD != mod241_pkg::MOD) begin : g_bad_mod
    $error("mod241_digit_serial_mul: MOD must be 241");
  end
  if ((DIGIT_W != 2) && (DIGIT_W != 4)) begin : g_bad_digit
    $error("mod241_digit_serial_mul: DIGIT_W must be 2 or 4");
  end

  state_t     state_q, state_n;
  logic [7:0] acc_q, acc_n;
  logic [2:0] cnt_q, cnt_n;
  logic [7:0] a_q, a_n;
  logic [7:0] b_q, b_n;
  logic [7:0] out_p_q, out_p_n;
  logic       out_valid_q, out_valid_n;
  logic       in_ready_q, in_ready_n;
  logic       accept;
  logic [7:0] step_nxt;

  mod241_digit_step #(.DIGIT_W(DIGIT_W)) u_step (
    .acc (acc_q),
    .a   (a_q),
    .d   (b_q[7 -: DIGIT_W]),
    .nxt (step_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      acc_q       <= acc_n;
      cnt_q       <= cnt_n;
      a_q         <= a_n;
      b_q         <= b_n;
      out_p_q     <= out_p_n;
      out_valid_q <= out_valid_n;
      in_ready_q  <= in_ready_n;
    end
  end

  // b is shifted left each RUN cycle so the current digit is always b_q's top bits.
  always_comb begin
    state_n     = state_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    a_n         = a_q;
    b_n         = b_q;
    out_p_n     = out_p_q;
    out_valid_n = out_valid_q;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept  = 1'b1;
          a_n     = reduce8(bus.in_a);
          b_n     = bus.in_b;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = step_nxt;
        b_n   = b_q << DIGIT_W;
        cnt_n = cnt_q + 3'd1;
        if (cnt_q == 3'(NDIG - 1)) begin
          out_p_n     = step_nxt;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    in_ready_n = (state_n == IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;

`ifdef MOD241_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= (bus.in_a >= 8'd241) | (bus.in_b >= 8'd241);
    end
  end

  assign bus.out_err = out_valid_q & err_q;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod241_digit_serial_mul.sv
// Scoreboard bench for mod241_digit_serial_mul: driver pushes expected results,
// a negedge monitor pops and compares on every out_valid & out_ready transfer.
module tb_mod241_digit_serial_mul;

  parameter int unsigned DIGIT_W = 4;
  localparam int unsigned NDIG   = 8 / DIGIT_W;
  localparam int unsigned NRAND  = 3000;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   rnd_rdy = 1'b0;
  logic [8:0] exp_q[$];

  mod241_digit_serial_mul_if bus ();

  mod241_digit_serial_mul #(.DIGIT_W(DIGIT_W), .MOD(241)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic [7:0] a, input logic [7:0] b);
`ifdef MOD241_RANGE_CHECK_EN
    return (a >= 8'd241) || (b >= 8'd241);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit push);
    int unsigned n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      cyc();
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back({exp_err(a, b), 8'((int'(a) * int'(b)) % 241)});
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cyc();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(bus.out_p), -1);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("result_p", int'(bus.out_p), int'(e[7:0]));
        chk("result_err", int'(bus.out_err), int'(e[8]));
      end
    end
  end

  initial begin
    forever begin
      cyc();
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    logic [7:0]  ra, rb;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_p", int'(bus.out_p), 0);
    chk("reset_out_err", int'(bus.out_err), 0);
    rst_n = 1'b1;
    cyc();
    chk("post_reset_in_ready", int'(bus.in_ready), 1);

    // 123*45 = 5535 = 233 mod 241; latency and first-digit accumulator
    bus.out_ready = 1'b1;
    send(8'd123, 8'd45, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      cyc();
      k++;
      if (k == 1) chk("acc_after_hi_digit", int'(dut.acc_q), (123 * (45 >> (8 - DIGIT_W))) % 241);
    end
    chk("latency_cycles", int'(k), int'(NDIG));
    cyc();
    chk("single_transfer_drop", int'(bus.out_valid), 0);
    drain();

    send(8'd240, 8'd240, 1'b1);  // 1
    send(8'd16, 8'd16, 1'b1);    // 15
    send(8'd0, 8'd200, 1'b1);    // 0
    send(8'd255, 8'd2, 1'b1);    // 28, err if range check on
    send(8'd3, 8'd4, 1'b1);      // 12
    drain();

    // backpressure: 200*3 = 600 = 118 mod 241
    bus.out_ready = 1'b0;
    send(8'd200, 8'd3, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      cyc();
      k++;
    end
    chk("bp_out_valid_rise", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.in_a     = 8'd9;
      bus.in_b     = 8'd9;
      cyc();
      chk("bp_out_valid_hold", int'(bus.out_valid), 1);
      chk("bp_out_p_hold", int'(bus.out_p), 118);
      chk("bp_in_ready_low", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_release_out_valid", int'(bus.out_valid), 0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    chk("bp_queue_empty", exp_q.size(), 0);

    // reset mid-RUN discards the operation
    send(8'd50, 8'd60, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_p", int'(bus.out_p), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("midrst_release_in_ready", int'(bus.in_ready), 1);
    repeat (6) cyc();
    chk("midrst_no_stale", int'(bus.out_valid), 0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < int'(NRAND); i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) cyc();
      send(ra, rb, 1'b1);
    end
    drain();
    rnd_rdy       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
